// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Device-side command decoder for the UART matrix-multiply link.
//   It takes a command byte and four dimension bytes from the host. It validates
//   the dimensions and answers with one ACK or NAK byte. It then packs the
//   big-endian FP32 operand bytes into 32-bit words. These words are written
//   row-major into buffer A, then buffer H. A one-cycle start pulse follows the
//   last H word.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   rx_valid, rx_data         one-cycle byte strobe and received byte
//   tx_send, tx_data          one-cycle transmit request; byte held until tx_done
//   tx_done                   transmitter finished (level or pulse)
//   wr_en, wr_sel, wr_addr,   operand write strobe, buffer select (0=A, 1=H),
//   wr_data                   row-major element index, assembled FP32 word
//   a_height, a_width,        dimensions latched from the header
//   h_height, h_width
//   start                     one-cycle pulse after the last H word is written
//   busy                      high whenever the parser is not idle
//   err                       one-cycle pulse on NAK or inter-byte timeout
module uart_cmd_parser #(
  parameter logic [7:0]  CMD_MATRIX_MULT = 8'h02,
  parameter logic [7:0]  ACK_BYTE        = 8'hA5,
  parameter logic [7:0]  NAK_BYTE        = 8'h5A,
  parameter int unsigned MAX_DIM         = 8,
  parameter int unsigned ADDR_W          = 6,
  parameter int unsigned TIMEOUT_CYCLES  = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_send,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [7:0]        a_height,
  output logic [7:0]        a_width,
  output logic [7:0]        h_height,
  output logic [7:0]        h_width,
  output logic              start,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CW    = ADDR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]       MAX_DIM_B = 8'(MAX_DIM);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, CHECK, REPLY, REPLY_WAIT, LOAD_A, LOAD_H, FIRE
  } state_t;

  state_t          state, state_next;
  logic [1:0]      hdr_cnt;
  logic [1:0]      byte_idx;
  logic [CW-1:0]   elem_idx, elem_inc, a_cnt, h_cnt, cur_cnt;
  logic [23:0]     asm_q;
  logic [31:0]     asm_next;
  logic [TMO_W-1:0] tmo_cnt;
  logic            hdr_ok, hdr_legal;
  logic            tx_done_q, tx_rise;
  logic            in_load, word_done, last_word, timeout_hit, err_set;

  assign tx_rise  = tx_done & ~tx_done_q;
  assign in_load  = (state == LOAD_A) || (state == LOAD_H);
  assign cur_cnt  = (state == LOAD_H) ? h_cnt : a_cnt;
  assign elem_inc = elem_idx + 1'b1;
  assign asm_next = {asm_q, rx_data};

  assign word_done   = in_load && rx_valid && (byte_idx == 2'd3);
  assign last_word   = word_done && (elem_inc == cur_cnt);
  // tmo_cnt holds the number of cycles since the last byte, so firing one
  // cycle early lets the registered err land exactly TIMEOUT_CYCLES later.
  assign timeout_hit = ((state == HDR) || in_load) && !rx_valid &&
                       (tmo_cnt == TMO_LAST);

  assign hdr_legal = (a_height != 8'd0) && (a_height <= MAX_DIM_B) &&
                     (a_width  != 8'd0) && (a_width  <= MAX_DIM_B) &&
                     (h_height != 8'd0) && (h_height <= MAX_DIM_B) &&
                     (h_width  != 8'd0) && (h_width  <= MAX_DIM_B) &&
                     (a_width == h_height);

  assign tx_send = (state == REPLY);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == CMD_MATRIX_MULT)) state_next = HDR;
      end
      HDR: begin
        if (timeout_hit) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end else if (rx_valid && (hdr_cnt == 2'd3)) begin
          state_next = CHECK;
        end
      end
      CHECK: state_next = REPLY;
      REPLY: state_next = REPLY_WAIT;
      REPLY_WAIT: begin
        if (tx_rise) begin
          if (hdr_ok) begin
            state_next = LOAD_A;
          end else begin
            state_next = IDLE;
            err_set    = 1'b1;
          end
        end
      end
      LOAD_A: begin
        if (timeout_hit) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end else if (last_word) begin
          state_next = LOAD_H;
        end
      end
      LOAD_H: begin
        if (timeout_hit) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end else if (last_word) begin
          state_next = FIRE;
        end
      end
      FIRE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_done_q <= 1'b0;
      tx_data   <= '0;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      a_height  <= '0;
      a_width   <= '0;
      h_height  <= '0;
      h_width   <= '0;
      start     <= 1'b0;
      err       <= 1'b0;
      hdr_cnt   <= '0;
      byte_idx  <= '0;
      elem_idx  <= '0;
      a_cnt     <= '0;
      h_cnt     <= '0;
      asm_q     <= '0;
      hdr_ok    <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      tx_done_q <= tx_done;
      wr_en     <= 1'b0;
      start     <= (state == FIRE);
      err       <= err_set;

      if (rx_valid || !((state == HDR) || in_load)) tmo_cnt <= TMO_W'(1);
      else                                          tmo_cnt <= tmo_cnt + 1'b1;

      if (state == IDLE) hdr_cnt <= '0;

      if ((state == HDR) && rx_valid) begin
        case (hdr_cnt)
          2'd0:    a_height <= rx_data;
          2'd1:    a_width  <= rx_data;
          2'd2:    h_height <= rx_data;
          default: h_width  <= rx_data;
        endcase
        hdr_cnt <= hdr_cnt + 1'b1;
      end

      if (state == CHECK) begin
        hdr_ok  <= hdr_legal;
        tx_data <= hdr_legal ? ACK_BYTE : NAK_BYTE;
        a_cnt   <= CW'(a_height) * CW'(a_width);
        h_cnt   <= CW'(h_height) * CW'(h_width);
      end

      // Leaving the load states (including via timeout) drops any partial word.
      if (!in_load) begin
        byte_idx <= '0;
        elem_idx <= '0;
      end else if (rx_valid) begin
        asm_q    <= asm_next[23:0];
        byte_idx <= byte_idx + 1'b1;
        if (word_done) begin
          wr_en    <= 1'b1;
          wr_sel   <= (state == LOAD_H);
          wr_addr  <= elem_idx[ADDR_W-1:0];
          wr_data  <= asm_next;
          elem_idx <= last_word ? '0 : elem_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser. It runs table vectors and randomized
// transfers against a transaction-level model: header legality, expected
// writes and event timing. It also runs hand sequences for garbage,
// timeout and mid-transfer reset.
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 300;
  localparam int unsigned AW  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_done = 1'b0;
  logic          tx_send, wr_en, wr_sel, start, busy, err;
  logic [7:0]    tx_data, a_height, a_width, h_height, h_width;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  uart_cmd_parser #(
    .CMD_MATRIX_MULT(8'h02),
    .ACK_BYTE(8'hA5),
    .NAK_BYTE(8'h5A),
    .MAX_DIM(8),
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_send(tx_send), .tx_data(tx_data), .tx_done(tx_done),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .a_height(a_height), .a_width(a_width), .h_height(h_height), .h_width(h_width),
    .start(start), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   cyc;
    logic          sel;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         wr_q[$];
  int unsigned tx_cyc_q[$];
  logic [7:0]  tx_dat_q[$];
  int unsigned start_q[$];
  int unsigned err_q[$];
  logic [31:0] fixed_words[$];

  always @(negedge clk) begin
    if (tx_send) begin
      tx_cyc_q.push_back(cyc);
      tx_dat_q.push_back(tx_data);
    end
    if (wr_en) wr_q.push_back('{cyc, wr_sel, wr_addr, wr_data});
    if (start) start_q.push_back(cyc);
    if (err)   err_q.push_back(cyc);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack_wr(input wr_t w);
    return {w.cyc[24:0], w.sel, w.addr, w.data};
  endfunction

  // Header legality straight from the protocol rules.
  function automatic bit model_legal(input logic [7:0] ah, aw, hh, hw);
    return (ah inside {[8'd1:8'd8]}) && (aw inside {[8'd1:8'd8]}) &&
           (hh inside {[8'd1:8'd8]}) && (hw inside {[8'd1:8'd8]}) && (aw == hh);
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
  endtask

  task automatic clear_q();
    wr_q.delete(); tx_cyc_q.delete(); tx_dat_q.delete();
    start_q.delete(); err_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, output int unsigned c);
    rx_valid = 1'b1;
    rx_data  = b;
    c = cyc;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_header(input logic [7:0] ah, aw, hh, hw, output int unsigned last);
    int unsigned c;
    send_byte(8'h02, c); gap();
    send_byte(ah, c);    gap();
    send_byte(aw, c);    gap();
    send_byte(hh, c);    gap();
    send_byte(hw, last);
  endtask

  task automatic send_word(input logic [31:0] w, output int unsigned last);
    int unsigned c;
    send_byte(w[31:24], c); gap();
    send_byte(w[23:16], c); gap();
    send_byte(w[15:8], c);  gap();
    send_byte(w[7:0], last);
  endtask

  task automatic expect_reply(input logic [7:0] exp, input int unsigned hdr_last,
                              input bit drop_byte, output int unsigned done_cyc);
    for (int i = 0; i < 20 && tx_cyc_q.size() == 0; i++) tick(1);
    check("tx_send count", 64'(tx_cyc_q.size()), 64'd1);
    if (tx_cyc_q.size() > 0) begin
      check("tx_send timing", 64'(tx_cyc_q[0]), 64'(hdr_last + 2));
      check("tx_data reply", 64'(tx_dat_q[0]), 64'(exp));
    end
    tick($urandom_range(1, 4));
    check("tx_data held", 64'(tx_data), 64'(exp));
    tx_done = 1'b1;
    if (drop_byte) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    done_cyc = cyc;
    tick(1);
    tx_done  = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic do_xfer(input logic [7:0] ah, aw, hh, hw, input bit exp_ack,
                         input int unsigned n_junk);
    int unsigned hl, dc, l, lw, na, nh;
    logic [31:0] w;
    logic [7:0]  j;
    wr_t exp_q[$];
    clear_q();
    for (int unsigned k = 0; k < n_junk; k++) begin
      j = 8'($urandom);
      if (j == 8'h02) j = 8'h03;
      send_byte(j, l);
      gap();
    end
    send_header(ah, aw, hh, hw, hl);
    expect_reply(exp_ack ? 8'hA5 : 8'h5A, hl, 1'($urandom_range(0, 1)), dc);
    if (!exp_ack) begin
      tick(3);
      check("nak err count", 64'(err_q.size()), 64'd1);
      if (err_q.size() > 0) check("nak err timing", 64'(err_q[0]), 64'(dc + 1));
      check("nak writes", 64'(wr_q.size()), 64'd0);
      check("nak start", 64'(start_q.size()), 64'd0);
      check("nak busy", 64'(busy), 64'd0);
    end else begin
      check("dims latched", 64'({a_height, a_width, h_height, h_width}),
            64'({ah, aw, hh, hw}));
      na = 32'(ah) * 32'(aw);
      nh = 32'(hh) * 32'(hw);
      lw = 0;
      for (int unsigned i = 0; i < na + nh; i++) begin
        if (fixed_words.size() > 0) w = fixed_words.pop_front();
        else                        w = $urandom;
        gap();
        send_word(w, l);
        lw = l + 1;
        exp_q.push_back('{lw, (i >= na), AW'((i >= na) ? i - na : i), w});
      end
      tick(4);
      check("write count", 64'(wr_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
        check($sformatf("write %0d {cyc,sel,addr,data}", i), pack_wr(wr_q[i]), pack_wr(exp_q[i]));
      check("start count", 64'(start_q.size()), 64'd1);
      if (start_q.size() > 0) check("start timing", 64'(start_q[0]), 64'(lw + 1));
      check("ack err count", 64'(err_q.size()), 64'd0);
      check("ack busy after", 64'(busy), 64'd0);
    end
  endtask

  typedef struct {
    logic [7:0] ah, aw, hh, hw;
    bit         ack;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hl, dc, l, c;
    logic [7:0] rah, raw, rhh, rhw;

    vecs = '{
      '{8'd2, 8'd2, 8'd2, 8'd2, 1'b1},
      '{8'd2, 8'd3, 8'd2, 8'd2, 1'b0},
      '{8'd0, 8'd1, 8'd1, 8'd1, 1'b0},
      '{8'd9, 8'd1, 8'd1, 8'd1, 1'b0},
      '{8'd1, 8'd1, 8'd1, 8'd9, 1'b0},
      '{8'd8, 8'd8, 8'd8, 8'd8, 1'b1},
      '{8'd1, 8'd1, 8'd1, 8'd1, 1'b1},
      '{8'd3, 8'd2, 8'd2, 8'd4, 1'b1},
      '{8'd8, 8'd1, 8'd1, 8'd8, 1'b1},
      '{8'd2, 8'd0, 8'd0, 8'd2, 1'b0},
      '{8'd1, 8'd9, 8'd9, 8'd1, 1'b0}
    };

    // Reset state
    tick(3);
    check("reset ctl {tx_send,wr_en,wr_sel,start,busy,err}",
          64'({tx_send, wr_en, wr_sel, start, busy, err}), 64'd0);
    check("reset tx_data", 64'(tx_data), 64'd0);
    check("reset wr_addr/wr_data", 64'({wr_addr, wr_data}), 64'd0);
    check("reset dims", 64'({a_height, a_width, h_height, h_width}), 64'd0);
    rst = 1'b0;
    tick(2);

    // Known operand words for the first 2x2 vector
    fixed_words = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    for (int i = 0; i < 11; i++) begin
      do_xfer(vecs[i].ah, vecs[i].aw, vecs[i].hh, vecs[i].hw, vecs[i].ack, 0);
      tick(2);
    end

    // Garbage before a command
    clear_q();
    send_byte(8'hFF, c);
    send_byte(8'h00, c);
    tick(3);
    check("garbage no reply", 64'(tx_cyc_q.size()), 64'd0);
    check("garbage busy", 64'(busy), 64'd0);
    do_xfer(8'd1, 8'd1, 8'd1, 8'd1, 1'b1, 0);
    tick(2);

    // Timeout after two bytes of the first A word
    clear_q();
    send_header(8'd2, 8'd2, 8'd2, 8'd2, hl);
    expect_reply(8'hA5, hl, 1'b0, dc);
    send_byte(8'h3F, c);
    send_byte(8'h80, l);
    for (int i = 0; i < int'(TMO) + 20 && err_q.size() == 0; i++) tick(1);
    tick(2);
    check("timeout err count", 64'(err_q.size()), 64'd1);
    if (err_q.size() > 0) check("timeout err timing", 64'(err_q[0]), 64'(l + TMO));
    check("timeout writes", 64'(wr_q.size()), 64'd0);
    check("timeout no second reply", 64'(tx_cyc_q.size()), 64'd1);
    check("timeout busy", 64'(busy), 64'd0);
    do_xfer(8'd1, 8'd1, 8'd1, 8'd1, 1'b1, 0);
    tick(2);

    // Reset in the middle of LOAD_H
    clear_q();
    send_header(8'd2, 8'd2, 8'd2, 8'd2, hl);
    expect_reply(8'hA5, hl, 1'b0, dc);
    for (int i = 0; i < 5; i++) send_word($urandom, l);
    send_byte(8'h12, c);
    send_byte(8'h34, c);
    rst = 1'b1;
    tick(1);
    check("midrst ctl {tx_send,wr_en,wr_sel,start,busy,err}",
          64'({tx_send, wr_en, wr_sel, start, busy, err}), 64'd0);
    check("midrst data {tx_data,wr_addr,wr_data}", 64'({tx_data, wr_addr, wr_data}), 64'd0);
    check("midrst dims", 64'({a_height, a_width, h_height, h_width}), 64'd0);
    rst = 1'b0;
    tick(5);
    check("midrst writes before reset", 64'(wr_q.size()), 64'd5);
    check("midrst no start", 64'(start_q.size()), 64'd0);
    check("midrst no err", 64'(err_q.size()), 64'd0);
    do_xfer(8'd2, 8'd2, 8'd2, 8'd2, 1'b1, 0);
    tick(2);

    // Randomized headers, junk prefixes and inter-byte gaps
    for (int t = 0; t < 30; t++) begin
      rah = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(1, 4));
      raw = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(1, 4));
      rhh = ($urandom_range(0, 3) != 0) ? raw : 8'($urandom_range(0, 9));
      rhw = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 4));
      do_xfer(rah, raw, rhh, rhw, model_legal(rah, raw, rhh, rhw), $urandom_range(0, 2));
      tick($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
